mcspi_responder: RTL
====================

# mcspi_responder

SPI responder that terminates the Beagle McSPI3 link (CS0, SIMO, SOMI, CLK on the expansion connector) inside the FPGA. It decodes 16-bit command frames into register write strobes and read requests for the on-chip control register file. On reads, it returns data on SOMI in the same frame. It runs entirely in the `master_clk` domain, oversampling the SPI pins, and sits between the expansion-connector pins and the radio control registers.

## Interface
- `ADDR_W`, default 7: register address width; frame bits [14:8].
- `DATA_W`, default 8: register data width; frame bits [7:0].
- `SYNC_STAGES`, default 2: synchronizer depth on `spi_clk`, `spi_cs_n`, `spi_simo`.
- `master_clk`  in  1  sole clock; all logic rising-edge.
- `reset`  in  1  asynchronous, active-high reset.
- `spi_clk`  in  1  McSPI3_CLK, asynchronous to `master_clk`; mode 0 (CPOL=0, CPHA=0).
- `spi_cs_n`  in  1  McSPI3_CS0, active low.
- `spi_simo`  in  1  McSPI3_SIMO, MSB first.
- `spi_somi`  out  1  McSPI3_SOMI data.
- `spi_somi_oe`  out  1  SOMI output enable; high while CS is asserted (synchronized).
- `reg_addr`  out  ADDR_W  address; held from command capture to end of frame.
- `reg_wdata`  out  DATA_W  write data; valid while `reg_wr` is high.
- `reg_wr`  out  1  one-cycle write strobe.
- `reg_rd`  out  1  one-cycle read request.
- `reg_rdata`  in  DATA_W  read data, sampled exactly 1 cycle after `reg_rd`.
- `busy`  out  1  high from CS assertion detect to frame end.
- `err_count`  out  8  aborted-frame counter; present only with `MCSPI_RESPONDER_ERR_EN`.

## Operation
- Frame format: 16 bits, MSB first. Bit 15 = R/W (1 = read). Bits 14:8 = address. Bits 7:0 = write data, or don't-care on reads.
- Input handling: synchronize `spi_clk`, `spi_cs_n` and `spi_simo`, then edge-detect the synchronized `spi_clk` and `spi_cs_n`. SIMO is sampled on detected `spi_clk` rising edges. SOMI shifts on detected falling edges.
- FSM states:
  - IDLE → CMD on CS falling.
  - CMD → DATA after the 8th rising edge.
  - DATA → DONE after the 16th rising edge.
  - DONE → IDLE on CS rising.
  - Any state → IDLE on CS rising.
- Bit counter: 4 bits. Cleared on CS falling; increments on each rising edge.
- Write (bit 15 = 0): on the 16th rising edge, pulse `reg_wr` for 1 cycle with `reg_addr` and `reg_wdata`.
- Read (bit 15 = 1):
  - Pulse `reg_rd` on the cycle after the 8th rising edge is detected.
  - Capture `reg_rdata` into the TX shift register 1 cycle later.
  - Drive the MSB on SOMI at the 8th falling edge, then shift on each subsequent falling edge.
- `spi_somi` during CMD and write frames: 0.
- Abort (CS rising before 16 bits): return to IDLE with no `reg_wr`. A `reg_rd` already issued is not retracted.
- Extra clocks in DONE (more than 16): ignored. No strobes, SOMI = 0.
- Reset values: `spi_somi` = 0, `spi_somi_oe` = 0, `reg_addr` = 0, `reg_wdata` = 0, `reg_wr` = 0, `reg_rd` = 0, `busy` = 0, `err_count` = 0, state = IDLE.
- Reset mid-frame: immediately drop to IDLE. The remainder of that frame is ignored until the next CS falling edge.

## Timing
- Detection latency: a pin edge is detected `SYNC_STAGES` + 1 `master_clk` cycles after it occurs.
- `spi_clk` frequency must be ≤ `master_clk`/8, so each SCLK half-period is ≥ 4 cycles. Faster clocks are unsupported.
- `reg_wr` rises 1 cycle after detection of the 16th rising edge.
- Read path: `reg_rd` at rising-detect + 1; `reg_rdata` sampled at + 2; data loaded before the 8th falling-edge detect.
- CS deassert to rising edge minimum: 2 `master_clk` cycles.
- Back-to-back frames: CS high for ≥ `SYNC_STAGES` + 2 cycles between frames.

## Configuration
- `MCSPI_RESPONDER_ERR_EN` defined:
  - `err_count` port exists.
  - It increments on each aborted frame (CS rising with bit count not equal to 16) and saturates at 255.
- Undefined: no `err_count` port and no counter logic. Abort behaviour is otherwise identical.

## Structure
- `mcspi_pkg` holds:
  - the FSM state enum (IDLE, CMD, DATA, DONE);
  - `FRAME_BITS` = 16 and `CMD_BITS` = 8;
  - the R/W bit index.
- Sub-module `mcspi_sync`: one instance per pin. It contains the `SYNC_STAGES` flop chain plus rise/fall pulse outputs.

## Test plan
- Write frame 0x05A7 (address 0x05, data 0xA7) at SCLK = `master_clk`/8 → exactly one `reg_wr` pulse with `reg_addr` = 0x05 and `reg_wdata` = 0xA7; `reg_rd` never asserts.
- Read frame 0x8A00 with `reg_rdata` = 0x3C → one `reg_rd` pulse with `reg_addr` = 0x0A; SOMI bits 8–15 sampled on rising edges = 0x3C; SOMI = 0 during bits 0–7.
- CS raised after 11 bits of a write frame → no `reg_wr`; FSM returns to IDLE; `err_count` = 1 (macro on).
- Assert `reset` mid-read at bit 10 → all outputs return to their reset values within 1 cycle; the next full write frame 0x7F55 produces a correct `reg_wr`.
- Two back-to-back frames (write 0x0111, then read 0x8100) with minimum CS-high gap → both decoded correctly; SOMI returns 0x11.
- 20 SCLK pulses in one write frame → single `reg_wr` pulse from the first 16 bits; extra bits ignored; `err_count` unchanged.

Source files
------------

// File: rtl/mcspi_pkg.sv
// Shared definitions for the McSPI3 responder: FSM states and frame geometry.
package mcspi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int FRAME_BITS = 16;
  localparam int CMD_BITS   = 8;
  localparam int RW_BIT     = 15;
  localparam int CNT_W      = 4;

endpackage

// File: rtl/mcspi_sync.sv
// Single-pin synchronizer with registered rise/fall pulses, all aligned with level.
module mcspi_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   prev;
  // vld_p tracks which chain positions hold real pin samples since reset,
  // so a pin already low at reset release is not mistaken for an edge.
  logic [SYNC_STAGES:0]   vld_p;
  logic                   sync_lvl;

  assign sync_lvl = chain[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= {SYNC_STAGES{RST_VAL}};
      prev  <= RST_VAL;
      vld_p <= '0;
      level <= RST_VAL;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      chain <= SYNC_STAGES'({chain, din});
      prev  <= sync_lvl;
      vld_p <= (SYNC_STAGES+1)'({vld_p, 1'b1});
      level <= sync_lvl;
      rise  <= vld_p[SYNC_STAGES] & sync_lvl & ~prev;
      fall  <= vld_p[SYNC_STAGES] & ~sync_lvl & prev;
    end
  end

endmodule

// File: rtl/mcspi_responder.sv
// McSPI3 responder: 16-bit R/W command frames to register strobes, read data on SOMI.
// Optional aborted-frame counter enabled by defining MCSPI_RESPONDER_ERR_EN.
module mcspi_responder
  import mcspi_pkg::*;
#(
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              master_clk,
  input  logic              reset,
  input  logic              spi_clk,
  input  logic              spi_cs_n,
  input  logic              spi_simo,
  output logic              spi_somi,
  output logic              spi_somi_oe,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              reg_wr,
  output logic              reg_rd,
  input  logic [DATA_W-1:0] reg_rdata,
  output logic              busy
`ifdef MCSPI_RESPONDER_ERR_EN
  ,
  output logic [7:0]        err_count
`endif
);

  localparam int SR_W = CMD_BITS - 1;
  localparam int CMD_RW = RW_BIT - (FRAME_BITS - CMD_BITS);
  localparam logic [CNT_W-1:0] CNT_CMD_LAST   = CNT_W'(CMD_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_FRAME_LAST = CNT_W'(FRAME_BITS - 1);

  logic sclk_rise, sclk_fall, unused_sclk_lvl;
  logic cs_rise, cs_fall, cs_lvl;
  logic simo_lvl, unused_simo_rise, unused_simo_fall;

  mcspi_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(master_clk), .rst(reset), .din(spi_clk),
    .level(unused_sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
  );

  mcspi_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk(master_clk), .rst(reset), .din(spi_cs_n),
    .level(cs_lvl), .rise(cs_rise), .fall(cs_fall)
  );

  mcspi_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_simo (
    .clk(master_clk), .rst(reset), .din(spi_simo),
    .level(simo_lvl), .rise(unused_simo_rise), .fall(unused_simo_fall)
  );

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     bit_cnt;
  logic [SR_W-1:0]      rx_sr;
  logic [CMD_BITS-1:0]  cur_byte;
  logic                 is_rd;
  logic                 cmd_last, frame_last, abort;
  logic                 rd_p1;
  logic [DATA_W-1:0]    tx_sr;

  assign cur_byte   = {rx_sr, simo_lvl};
  assign cmd_last   = (state == ST_CMD)  && sclk_rise && (bit_cnt == CNT_CMD_LAST);
  assign frame_last = (state == ST_DATA) && sclk_rise && (bit_cnt == CNT_FRAME_LAST);
  assign abort      = cs_rise && ((state == ST_CMD) || (state == ST_DATA));

  assign busy        = (state != ST_IDLE);
  assign spi_somi_oe = ~cs_lvl;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (cs_fall)  state_nxt = ST_CMD;
      ST_CMD:  if (cmd_last) state_nxt = ST_DATA;
      ST_DATA: if (frame_last) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_DONE;
      default: state_nxt = ST_IDLE;
    endcase
    if (cs_rise) state_nxt = ST_IDLE;
  end

  always_ff @(posedge master_clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Stage p0: bit counting, command capture and strobe generation
  always_ff @(posedge master_clk or posedge reset) begin
    if (reset) begin
      bit_cnt   <= '0;
      is_rd     <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_wr    <= 1'b0;
      reg_rd    <= 1'b0;
    end else begin
      if (cs_fall)
        bit_cnt <= '0;
      else if (sclk_rise && state != ST_IDLE)
        bit_cnt <= bit_cnt + 1'b1;

      if (cmd_last) begin
        is_rd    <= cur_byte[CMD_RW];
        reg_addr <= cur_byte[ADDR_W-1:0];
      end

      reg_rd <= cmd_last && cur_byte[CMD_RW];
      reg_wr <= frame_last && !is_rd;
      if (frame_last && !is_rd)
        reg_wdata <= cur_byte[DATA_W-1:0];
    end
  end

  always_ff @(posedge master_clk) begin
    if (sclk_rise && state != ST_IDLE)
      rx_sr <= cur_byte[SR_W-1:0];
  end

  // Stage p1: register-file read data lands one cycle after reg_rd
  always_ff @(posedge master_clk or posedge reset) begin
    if (reset) rd_p1 <= 1'b0;
    else       rd_p1 <= reg_rd;
  end

  always_ff @(posedge master_clk) begin
    if (rd_p1)
      tx_sr <= reg_rdata;
    else if (sclk_fall && state == ST_DATA)
      tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
  end

  // Stage p2: SOMI launch on falling edges of the data half of a read frame
  always_ff @(posedge master_clk or posedge reset) begin
    if (reset)
      spi_somi <= 1'b0;
    else if (state == ST_DATA && is_rd) begin
      if (sclk_fall) spi_somi <= tx_sr[DATA_W-1];
    end else
      spi_somi <= 1'b0;
  end

`ifdef MCSPI_RESPONDER_ERR_EN
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_ff @(posedge master_clk or posedge reset) begin
    if (reset)      err_count <= 8'd0;
    else if (abort) err_count <= sat_inc8(err_count);
  end
`else
  logic unused_abort;
  assign unused_abort = abort;
`endif

endmodule
